nic_master_arbiter: RTL and testbench

//   Shares the single master port of the 4-slave NIC between NUM_MASTERS requesters.

---
 rtl/nic_master_arbiter.sv | 171 +++++++++++++++++
 tb/tb_nic_master_arbiter.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/nic_master_arbiter.sv
// rtl/nic_master_arbiter.sv - round-robin arbiter sharing the NIC master port
//
// Purpose:
//   Arbitrates NUM_MASTERS requesters onto the single master port of the
//   4-slave NIC. One transfer is in flight at a time. Each granted transfer
//   runs a SETUP cycle then an ACCESS cycle on the bus. Reads wait RD_LAT
//   cycles after ACCESS, capture bus_rdata and return it on rdata.
//
// Ports:
//   clk, rst              clock, synchronous active-high reset
//   req                   per-master request, held until its gnt bit
//   req_wr_dir            per-master direction (1 write, 0 read)
//   req_addr, req_wdata   per-master operands, 16 bits per master
//   gnt                   one-hot pulse in the SETUP cycle of the winner
//   done                  one-hot pulse when the winner's transfer completes
//   rdata                 read data, updated in the done cycle of a read
//   busy                  high in every state except IDLE
//   bus_sel, bus_enable   NIC master_sel / master_enable
//   bus_wr_dir            NIC master_wr_dir
//   bus_addr, bus_wdata   NIC master_addr / master_wdata
//   bus_rdata             NIC master_rdata

module nic_master_arbiter #(
  parameter int NUM_MASTERS = 4,
  parameter int RD_LAT      = 2
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_MASTERS-1:0]    req,
  input  logic [NUM_MASTERS-1:0]    req_wr_dir,
  input  logic [16*NUM_MASTERS-1:0] req_addr,
  input  logic [16*NUM_MASTERS-1:0] req_wdata,
  output logic [NUM_MASTERS-1:0]    gnt,
  output logic [NUM_MASTERS-1:0]    done,
  output logic [15:0]               rdata,
  output logic                      busy,
  output logic                      bus_sel,
  output logic                      bus_enable,
  output logic                      bus_wr_dir,
  output logic [15:0]               bus_addr,
  output logic [15:0]               bus_wdata,
  input  logic [15:0]               bus_rdata
);

  localparam int IDX_W = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;
  localparam int CNT_W = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_SETUP  = 3'd1,
    S_ACCESS = 3'd2,
    S_WAIT   = 3'd3,
    S_DONE   = 3'd4
  } state_t;

  state_t             state;
  logic [IDX_W-1:0]   last_winner;  // also the owner of the transfer in flight
  logic [IDX_W-1:0]   next_winner;
  logic               op_wr;
  logic [CNT_W-1:0]   wait_cnt;

  // Index of the master sitting 'off' positions after the last winner.
  function automatic logic [IDX_W-1:0] rr_index(input logic [IDX_W-1:0] base,
                                                 input int off);
    int sum;
    sum = (int'(base) + off) % NUM_MASTERS;
    return IDX_W'(sum);
  endfunction

  function automatic logic [NUM_MASTERS-1:0] onehot(input logic [IDX_W-1:0] idx);
    logic [NUM_MASTERS-1:0] v;
    v      = '0;
    v[idx] = 1'b1;
    return v;
  endfunction

  // Scan from the farthest position back to the nearest so that the closest
  // requester after last_winner is the one left standing.
  always_comb begin
    next_winner = last_winner;
    for (int i = NUM_MASTERS; i >= 1; i--) begin
      if (req[rr_index(last_winner, i)]) begin
        next_winner = rr_index(last_winner, i);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_IDLE;
      // Start with the last master as "previous winner" so master 0 is next.
      last_winner <= IDX_W'(NUM_MASTERS - 1);
      op_wr       <= 1'b0;
      wait_cnt    <= '0;
      gnt         <= '0;
      done        <= '0;
      rdata       <= '0;
      busy        <= 1'b0;
      bus_sel     <= 1'b0;
      bus_enable  <= 1'b0;
      bus_wr_dir  <= 1'b0;
      bus_addr    <= '0;
      bus_wdata   <= '0;
    end else begin
      gnt  <= '0;
      done <= '0;
      case (state)
        S_IDLE: begin
          if (|req) begin
            state       <= S_SETUP;
            last_winner <= next_winner;
            op_wr       <= req_wr_dir[next_winner];
            gnt         <= onehot(next_winner);
            busy        <= 1'b1;
            bus_sel     <= 1'b1;
            bus_enable  <= 1'b0;
            bus_wr_dir  <= req_wr_dir[next_winner];
            bus_addr    <= req_addr[int'(next_winner)*16 +: 16];
            bus_wdata   <= req_wr_dir[next_winner] ?
                           req_wdata[int'(next_winner)*16 +: 16] : 16'h0000;
          end
        end

        S_SETUP: begin
          state      <= S_ACCESS;
          bus_enable <= 1'b1;
        end

        S_ACCESS: begin
          bus_sel    <= 1'b0;
          bus_enable <= 1'b0;
          if (op_wr) begin
            state      <= S_DONE;
            done       <= onehot(last_winner);
            bus_wr_dir <= 1'b0;
            bus_wdata  <= 16'h0000;
          end else begin
            state    <= S_WAIT;
            wait_cnt <= CNT_W'(RD_LAT - 1);
          end
        end

        // bus_addr stays put here: the NIC steers its rdata mux with it.
        S_WAIT: begin
          if (wait_cnt == '0) begin
            state <= S_DONE;
            done  <= onehot(last_winner);
            rdata <= bus_rdata;
          end else begin
            wait_cnt <= wait_cnt - 1'b1;
          end
        end

        S_DONE: begin
          state <= S_IDLE;
          busy  <= 1'b0;
        end

        default: begin
          state      <= S_IDLE;
          busy       <= 1'b0;
          bus_sel    <= 1'b0;
          bus_enable <= 1'b0;
          bus_wr_dir <= 1'b0;
          bus_wdata  <= 16'h0000;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_nic_master_arbiter.sv
// tb/tb_nic_master_arbiter.sv - self-checking bench for nic_master_arbiter

module tb_nic_master_arbiter;

  localparam int N      = 4;
  localparam int RD_LAT = 2;

  logic              clk = 1'b0;
  logic              rst;
  logic [N-1:0]      req, req_wr_dir;
  logic [16*N-1:0]   req_addr, req_wdata;
  logic [N-1:0]      gnt, done;
  logic [15:0]       rdata;
  logic              busy, bus_sel, bus_enable, bus_wr_dir;
  logic [15:0]       bus_addr, bus_wdata, bus_rdata;

  always #5 clk = ~clk;

  nic_master_arbiter #(.NUM_MASTERS(N), .RD_LAT(RD_LAT)) dut (
    .clk(clk), .rst(rst),
    .req(req), .req_wr_dir(req_wr_dir), .req_addr(req_addr), .req_wdata(req_wdata),
    .gnt(gnt), .done(done), .rdata(rdata), .busy(busy),
    .bus_sel(bus_sel), .bus_enable(bus_enable), .bus_wr_dir(bus_wr_dir),
    .bus_addr(bus_addr), .bus_wdata(bus_wdata), .bus_rdata(bus_rdata)
  );

  // NIC + slave environment: 4 slaves x 16 words, RD_LAT-deep read pipe.
  logic [15:0] slv_mem [4][16] = '{default: '0};
  logic [15:0] rd_pipe [RD_LAT] = '{default: '0};

  always @(posedge clk) begin
    if (bus_sel && bus_enable && bus_wr_dir)
      slv_mem[bus_addr[15:14]][bus_addr[3:0]] <= bus_wdata;
    rd_pipe[0] <= (bus_sel && bus_enable && !bus_wr_dir) ?
                  slv_mem[bus_addr[15:14]][bus_addr[3:0]] : 16'hDEAD;
    for (int i = 1; i < RD_LAT; i++) rd_pipe[i] <= rd_pipe[i-1];
  end
  assign bus_rdata = rd_pipe[RD_LAT-1];

  // Transaction-level reference model.
  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  bit          act = 0;
  int          t_start, t_len, t_m;
  bit          t_wr;
  logic [15:0] t_addr, t_wdata;
  int          last_w = N - 1;
  logic [15:0] exp_rdata = '0;
  logic [15:0] ref_mem [logic [15:0]];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s cyc=%0d got=%0h exp=%0h", tag, cyc, got, exp);
    end
  endtask

  function automatic logic [15:0] ref_rd(input logic [15:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : 16'h0000;
  endfunction

  // Model effect of the posedge that ends the current cycle.
  task automatic advance();
    int k = 0;
    int win = 0;
    if (act) begin
      k = cyc - t_start;
      if (t_wr && k == 1) ref_mem[t_addr] = t_wdata;
    end
    if (rst) begin
      act = 0; last_w = N - 1; exp_rdata = '0;
    end else if (act) begin
      if (!t_wr && k + 1 == t_len - 1) exp_rdata = ref_rd(t_addr);
      if (k == t_len - 1) act = 0;
    end else if (req != '0) begin
      for (int i = 1; i <= N; i++) begin
        int m;
        m = (last_w + i) % N;
        if (req[m]) begin win = m; break; end
      end
      t_m = win; t_wr = req_wr_dir[win];
      t_addr = req_addr[16*win +: 16]; t_wdata = req_wdata[16*win +: 16];
      t_start = cyc + 1; t_len = t_wr ? 3 : 3 + RD_LAT;
      act = 1; last_w = win;
    end
  endtask

  task automatic check_outputs();
    logic [N-1:0] eg = '0, ed = '0;
    logic eb = 0, es = 0, ee = 0, ew = 0;
    logic [15:0] ewd = '0;
    int k;
    if (act) begin
      k   = cyc - t_start;
      eb  = 1;
      if (k == 0) eg = N'(1) << t_m;
      if (k == t_len - 1) ed = N'(1) << t_m;
      es  = (k <= 1);
      ee  = (k == 1);
      ew  = t_wr && (k <= 1);
      ewd = ew ? t_wdata : 16'h0000;
      if (k < t_len - 1) check("bus_addr", bus_addr, t_addr);
    end
    check("gnt", gnt, eg);
    check("done", done, ed);
    check("busy", busy, eb);
    check("bus_sel", bus_sel, es);
    check("bus_enable", bus_enable, ee);
    check("bus_wr_dir", bus_wr_dir, ew);
    check("bus_wdata", bus_wdata, ewd);
    check("rdata", rdata, exp_rdata);
  endtask

  task automatic step();
    advance();
    @(negedge clk);
    cyc++;
    check_outputs();
  endtask

  task automatic set_op(input int m, input bit wr, input logic [15:0] a, input logic [15:0] d);
    req_wr_dir[m]       = wr;
    req_addr[16*m +: 16]  = a;
    req_wdata[16*m +: 16] = d;
  endtask

  task automatic rand_op(input int m);
    set_op(m, 1'($urandom_range(0, 1)),
           {2'($urandom_range(0, 3)), 10'h000, 4'($urandom_range(0, 15))},
           16'($urandom));
  endtask

  task automatic run_idle();
    for (int i = 0; i < 30 && (act || req != '0); i++) step();
    check("idle_reached", act, 1'b0);
  endtask

  task automatic xfer(input int m, input bit wr, input logic [15:0] a, input logic [15:0] d,
                      input int lat, input bit chk_rd, input logic [15:0] exp_rd);
    int g = -1;
    int dn = -1;
    set_op(m, wr, a, d);
    req[m] = 1'b1;
    for (int i = 0; i < 40 && dn < 0; i++) begin
      step();
      if (gnt[m] === 1'b1) begin g = cyc; req[m] = 1'b0; end
      if (done[m] === 1'b1) begin
        dn = cyc;
        if (chk_rd) check("xfer_rdata", rdata, exp_rd);
      end
    end
    check("xfer_done_seen", dn >= 0, 1'b1);
    check("xfer_latency", dn - g, lat);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog cyc=%0d", cyc);
    $fatal(1);
  end

  initial begin
    int g, g0, g2, d2, ng;
    logic [N-1:0] ord [5];
    ord = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    rst = 1'b1; req = '0; req_wr_dir = '0; req_addr = '0; req_wdata = '0;

    // Reset then quiet bus.
    repeat (3) step();
    rst = 1'b0;
    repeat (20) begin
      step();
      check("idle_bus_addr", bus_addr, 16'h0000);
    end

    // Single write then read-back by master 1.
    xfer(1, 1'b1, 16'h4005, 16'hBEEF, 2, 1'b0, 16'h0000);
    xfer(1, 1'b0, 16'h4005, 16'h0000, 2 + RD_LAT, 1'b1, 16'hBEEF);
    run_idle();

    // All four requesting continuously, one slave each.
    rst = 1'b1; step(); rst = 1'b0; step();
    for (int m = 0; m < N; m++) set_op(m, 1'b1, {2'(m), 10'h000, 4'(m + 1)}, 16'hA000 + 16'(m));
    req = 4'b1111;
    ng = 0;
    for (int i = 0; i < 60 && ng < 5; i++) begin
      step();
      if (gnt !== '0) begin
        check("rr_order", gnt, ord[ng]);
        ng++;
      end
    end
    check("rr_grants_seen", ng, 5);
    req = '0;
    run_idle();

    // Master 0 requesting during master 2's read wait.
    xfer(2, 1'b1, 16'h8007, 16'h1234, 2, 1'b0, 16'h0000);
    set_op(2, 1'b0, 16'h8007, 16'h0000);
    req = 4'b0100;
    g2 = -1; d2 = -1; g0 = -1;
    for (int i = 0; i < 40 && g0 < 0; i++) begin
      step();
      if (gnt[2] === 1'b1) begin g2 = cyc; req[2] = 1'b0; end
      if (g2 >= 0 && cyc == g2 + 2) begin set_op(0, 1'b1, 16'h0009, 16'h5A5A); req[0] = 1'b1; end
      if (done[2] === 1'b1) begin d2 = cyc; check("t5_rdata", rdata, 16'h1234); end
      if (gnt[0] === 1'b1) begin g0 = cyc; req[0] = 1'b0; end
    end
    check("t5_gnt0_after_done", g0 - d2, 2);
    run_idle();
    check("t5_rdata_held", rdata, 16'h1234);

    // Reset during ACCESS.
    set_op(3, 1'b1, 16'hC00A, 16'h7777);
    req = 4'b1000;
    g = -1;
    for (int i = 0; i < 20 && g < 0; i++) begin
      step();
      if (gnt[3] === 1'b1) g = cyc;
    end
    step();
    check("t6_in_access", bus_enable, 1'b1);
    rst = 1'b1; req = 4'b1111;
    step();
    check("t6_no_done", done, 4'b0000);
    check("t6_sel_clear", bus_sel, 1'b0);
    rst = 1'b0;
    step();
    check("t6_first_gnt", gnt, 4'b0001);
    req = '0;
    run_idle();

    // Randomised traffic.
    for (int c = 0; c < 3000; c++) begin
      rst = ($urandom_range(0, 399) == 0);
      for (int m = 0; m < N; m++) begin
        if (!req[m]) begin
          if ($urandom_range(0, 3) == 0) begin rand_op(m); req[m] = 1'b1; end
        end else if ($urandom_range(0, 24) == 0) begin
          req[m] = 1'b0;
        end else if ($urandom_range(0, 4) == 0) begin
          rand_op(m);
        end
      end
      step();
      if (act && t_start == cyc) req[t_m] = 1'b0;
    end
    rst = 1'b0; req = '0;
    run_idle();

    for (int s = 0; s < 4; s++)
      for (int a = 0; a < 16; a++)
        check("slave_mem", slv_mem[s][a], ref_rd({2'(s), 10'h000, 4'(a)}));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
